// File: rtl/pokey_audio_pkg.sv
// Shared widths, frame geometry and sample limits for the POKEY audio to I2S path.
package pokey_audio_pkg;
  localparam int SAMPLE_W   = 16;
  localparam int FRAME_BITS = 32;
  localparam int SLOT_LOG2  = 5;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  localparam sample_t SAMPLE_MIN = 16'sh8000;
  localparam sample_t SAMPLE_MAX = 16'sh7FFF;
endpackage

// File: rtl/pokey_audio_i2s_pwm_integrator.sv
// Free-running window counter plus PWM integrator; converts each window's high count
// into a signed PCM sample and strobes it for one clk.
module pwm_integrator
  import pokey_audio_pkg::*;
#(
  parameter int WINDOW_LOG2 = 11
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic                   pwm_in,
  input  logic                   mute,
  output logic [WINDOW_LOG2-1:0] cnt_o,
  output sample_t                sample_o,
  output logic                   strobe_o
);
  localparam int SHIFT = SAMPLE_W - WINDOW_LOG2;

  logic [WINDOW_LOG2-1:0] cnt_q, cnt_d;
  logic [WINDOW_LOG2:0]   hi_q, hi_d, total;
  logic [SAMPLE_W-1:0]    scaled;
  sample_t                sample_q, sample_d;
  logic                   strobe_q, strobe_d;
  logic                   last;

  always_comb begin
    last     = &cnt_q;
    cnt_d    = cnt_q + 1'b1;
    total    = hi_q + {{WINDOW_LOG2{1'b0}}, pwm_in};
    hi_d     = last ? '0 : total;
    scaled   = SAMPLE_W'(total[WINDOW_LOG2-1:0]) << SHIFT;
    sample_d = sample_q;
    strobe_d = last;
    if (last) begin
      // A full window cannot be represented after the offset, so it pins to max.
      if (mute)                    sample_d = '0;
      else if (total[WINDOW_LOG2]) sample_d = SAMPLE_MAX;
      else                         sample_d = sample_t'(scaled - SAMPLE_MIN);
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt_q    <= '0;
      hi_q     <= '0;
      sample_q <= '0;
      strobe_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      sample_q <= sample_d;
      strobe_q <= strobe_d;
    end
  end

  assign cnt_o    = cnt_q;
  assign sample_o = sample_q;
  assign strobe_o = strobe_q;
endmodule

// File: rtl/pokey_audio_i2s.sv
// POKEY PWM audio to mono I2S: decimating integrator, optional DC blocker
// (POKEY_AUDIO_DCBLOCK_EN) and a 32-slot I2S serialiser locked to the window counter.
module pokey_audio_i2s #(
  parameter int WINDOW_LOG2 = 11,
  parameter int SAMPLE_W    = 16
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                pwm_in,
  input  logic                mute,
  output logic [SAMPLE_W-1:0] sample_o,
  output logic                sample_valid,
  output logic                bclk,
  output logic                lrclk,
  output logic                sdata
);
  import pokey_audio_pkg::*;

  localparam int SLOT_LSB = WINDOW_LOG2 - SLOT_LOG2;

  logic [WINDOW_LOG2-1:0] cnt;
  sample_t                raw;
  logic                   raw_stb;
  sample_t                cap;
  logic                   cap_stb;
  sample_t                load_half;

  pwm_integrator #(.WINDOW_LOG2(WINDOW_LOG2)) u_integ (
    .clk      (clk),
    .clr      (clr),
    .pwm_in   (pwm_in),
    .mute     (mute),
    .cnt_o    (cnt),
    .sample_o (raw),
    .strobe_o (raw_stb)
  );

`ifdef POKEY_AUDIO_DCBLOCK_EN
  logic signed [17:0] x_prev_q, x_prev_d, y_prev_q, y_prev_d, y_shift, y18;
  logic signed [19:0] y_wide;
  sample_t            dc_q, dc_d, y_sat;
  logic               dc_stb_q, dc_stb_d, mute_hold_q, mute_hold_d;

  always_comb begin
    mute_hold_d = mute_hold_q;
    if (&cnt) mute_hold_d = mute;
    y_shift = y_prev_q >>> 8;
    y_wide  = $signed({{4{raw[15]}}, raw}) - $signed({{2{x_prev_q[17]}}, x_prev_q})
            + $signed({{2{y_prev_q[17]}}, y_prev_q}) - $signed({{2{y_shift[17]}}, y_shift});
    if (y_wide > 20'sd131071)       y18 = 18'sh1FFFF;
    else if (y_wide < -20'sd131072) y18 = 18'sh20000;
    else                            y18 = y_wide[17:0];
    if (y18 > 18'sd32767)       y_sat = SAMPLE_MAX;
    else if (y18 < -18'sd32768) y_sat = SAMPLE_MIN;
    else                        y_sat = y18[15:0];
    x_prev_d = x_prev_q;
    y_prev_d = y_prev_q;
    dc_d     = dc_q;
    dc_stb_d = raw_stb;
    if (raw_stb) begin
      if (mute_hold_q) begin
        x_prev_d = '0;
        y_prev_d = '0;
        dc_d     = '0;
      end else begin
        x_prev_d = {{2{raw[15]}}, raw};
        y_prev_d = y18;
        dc_d     = y_sat;
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      x_prev_q    <= '0;
      y_prev_q    <= '0;
      dc_q        <= '0;
      dc_stb_q    <= 1'b0;
      mute_hold_q <= 1'b0;
    end else begin
      x_prev_q    <= x_prev_d;
      y_prev_q    <= y_prev_d;
      dc_q        <= dc_d;
      dc_stb_q    <= dc_stb_d;
      mute_hold_q <= mute_hold_d;
    end
  end

  // The frame loads on the same edge the filter output is registered, so take it pre-flop.
  assign cap       = dc_q;
  assign cap_stb   = dc_stb_q;
  assign load_half = dc_d;
`else
  assign cap       = raw;
  assign cap_stb   = raw_stb;
  assign load_half = raw;
`endif

  logic [FRAME_BITS-1:0] sreg_q, sreg_d;
  logic                  bclk_q, bclk_d, lrclk_q, lrclk_d;
  logic [SLOT_LOG2-1:0]  slot;

  // Outputs lag cnt by one clk, so every I2S edge lines up with the frame load.
  always_comb begin
    slot    = cnt[WINDOW_LOG2-1 -: SLOT_LOG2];
    bclk_d  = cnt[SLOT_LSB-1];
    lrclk_d = (slot >= 5'd15) && (slot <= 5'd30);
    sreg_d  = sreg_q;
    if (cnt == '0)                    sreg_d = {load_half, load_half};
    else if (cnt[SLOT_LSB-1:0] == '0) sreg_d = {sreg_q[FRAME_BITS-2:0], 1'b0};
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sreg_q  <= '0;
      bclk_q  <= 1'b0;
      lrclk_q <= 1'b0;
    end else begin
      sreg_q  <= sreg_d;
      bclk_q  <= bclk_d;
      lrclk_q <= lrclk_d;
    end
  end

  assign sample_o     = cap;
  assign sample_valid = cap_stb;
  assign bclk         = bclk_q;
  assign lrclk        = lrclk_q;
  assign sdata        = sreg_q[FRAME_BITS-1];
endmodule

// File: tb/tb_pokey_audio_i2s.sv
// Randomised bench for pokey_audio_i2s against a window-sum / frame-position reference model.
module tb_pokey_audio_i2s;
  localparam int WIN = 2048;
`ifdef POKEY_AUDIO_DCBLOCK_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        pwm_in = 1'b0;
  logic        mute = 1'b0;
  logic [15:0] sample_o;
  logic        sample_valid, bclk, lrclk, sdata;

  int vectors = 0;
  int miscompares = 0;

  int          cyc, acc, xp, yp, last_exp;
  logic [15:0] frame_word;
  int          exp_q[$], exp_cyc_q[$], obs_q[$], obs_cyc_q[$];

  pokey_audio_i2s dut (
    .clk          (clk),
    .clr          (clr),
    .pwm_in       (pwm_in),
    .mute         (mute),
    .sample_o     (sample_o),
    .sample_valid (sample_valid),
    .bclk         (bclk),
    .lrclk        (lrclk),
    .sdata        (sdata)
  );

  always #5 clk = ~clk;

  function automatic int clamp(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  task automatic reset_model();
    cyc = 0; acc = 0; xp = 0; yp = 0; last_exp = 0; frame_word = '0;
    exp_q.delete(); exp_cyc_q.delete(); obs_q.delete(); obs_cyc_q.delete();
  endtask

  task automatic do_reset();
    clr = 1'b1; pwm_in = 1'b0; mute = 1'b0;
    repeat (2) @(posedge clk);
    #2 clr = 1'b0;
    reset_model();
  endtask

  // One clk of stimulus; the model sums each window and records what the DUT emits.
  task automatic drive_cycle(input logic p);
    int raw, val, y;
    pwm_in = p;
    @(posedge clk);
    #1;
    cyc++;
    acc += int'(p);
    if (cyc % WIN == 0) begin
      if (mute) raw = 0;
      else if (acc == WIN) raw = 32767;
      else raw = acc * (65536 / WIN) - 32768;
      val = raw;
`ifdef POKEY_AUDIO_DCBLOCK_EN
      if (mute) begin
        xp = 0; yp = 0; val = 0;
      end else begin
        y = clamp(raw - xp + yp - (yp >>> 8), -131072, 131071);
        xp = raw; yp = y; val = clamp(y, -32768, 32767);
      end
`else
      y = 0;
`endif
      exp_q.push_back(val);
      exp_cyc_q.push_back(cyc + LAT);
      last_exp = val;
      acc = 0;
    end
    if (cyc % WIN == 1) frame_word = 16'(last_exp);
    if (sample_valid) begin
      obs_q.push_back(int'($signed(sample_o)));
      obs_cyc_q.push_back(cyc);
    end
  endtask

  task automatic test_reset();
    #3;
    vectors++; if (sample_o !== 16'h0000) begin miscompares++; $display("FAIL reset_sample: got %h want 0000", sample_o); end
    vectors++; if (sample_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", sample_valid); end
    vectors++; if (bclk !== 1'b0) begin miscompares++; $display("FAIL reset_bclk: got %b want 0", bclk); end
    vectors++; if (lrclk !== 1'b0) begin miscompares++; $display("FAIL reset_lrclk: got %b want 0", lrclk); end
    vectors++; if (sdata !== 1'b0) begin miscompares++; $display("FAIL reset_sdata: got %b want 0", sdata); end
  endtask

  task automatic test_const_low();
    do_reset();
    repeat (3 * WIN + LAT + 1) drive_cycle(1'b0);
    vectors++; if (obs_q.size() !== 3) begin miscompares++; $display("FAIL low_count: got %0d want 3", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      vectors++; if (obs_cyc_q[i] !== WIN * (i + 1) + LAT) begin miscompares++; $display("FAIL low_valid_time[%0d]: got %0d want %0d", i, obs_cyc_q[i], WIN * (i + 1) + LAT); end
      vectors++; if (obs_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL low_sample[%0d]: got %0d want %0d", i, obs_q[i], exp_q[i]); end
    end
`ifndef POKEY_AUDIO_DCBLOCK_EN
    vectors++; if (obs_q.size() < 1 || obs_q[0] !== -32768) begin miscompares++; $display("FAIL low_min: got %0d want -32768", obs_q.size() > 0 ? obs_q[0] : 0); end
`endif
  endtask

  task automatic test_const_high();
    do_reset();
    repeat (2 * WIN + LAT + 1) drive_cycle(1'b1);
    vectors++; if (obs_q.size() !== 2) begin miscompares++; $display("FAIL high_count: got %0d want 2", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      vectors++; if (obs_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL high_sample[%0d]: got %0d want %0d", i, obs_q[i], exp_q[i]); end
    end
    vectors++; if (obs_q.size() < 1 || obs_q[0] !== 32767) begin miscompares++; $display("FAIL high_sat: got %0d want 32767", obs_q.size() > 0 ? obs_q[0] : 0); end
`ifdef POKEY_AUDIO_DCBLOCK_EN
    vectors++; if (obs_q.size() < 2 || !(obs_q[1] < obs_q[0])) begin miscompares++; $display("FAIL dc_decay: got %0d want below 32767", obs_q.size() > 1 ? obs_q[1] : 0); end
`endif
  endtask

  task automatic test_toggle();
    do_reset();
    for (int k = 0; k < 2 * WIN + LAT + 1; k++) drive_cycle(k[0]);
    vectors++; if (obs_q.size() !== 2) begin miscompares++; $display("FAIL toggle_count: got %0d want 2", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      vectors++; if (obs_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL toggle_sample[%0d]: got %0d want %0d", i, obs_q[i], exp_q[i]); end
    end
    vectors++; if (obs_q.size() < 1 || obs_q[0] !== 0) begin miscompares++; $display("FAIL toggle_mid: got %0d want 0", obs_q.size() > 0 ? obs_q[0] : 0); end
  endtask

  task automatic test_random();
    int d;
    do_reset();
    for (int w = 0; w < 5; w++) begin
      d = (w == 0) ? WIN : $urandom_range(0, WIN);
      for (int k = 0; k < WIN; k++) begin
        mute = ($urandom_range(0, 3) == 0);
        drive_cycle($urandom_range(0, WIN - 1) < d);
      end
    end
    mute = 1'b0;
    repeat (LAT + 1) drive_cycle(1'b0);
    vectors++; if (obs_q.size() !== exp_q.size()) begin miscompares++; $display("FAIL rand_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      vectors++; if (obs_cyc_q[i] !== exp_cyc_q[i]) begin miscompares++; $display("FAIL rand_valid_time[%0d]: got %0d want %0d", i, obs_cyc_q[i], exp_cyc_q[i]); end
      vectors++; if (obs_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL rand_sample[%0d]: got %0d want %0d", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_frame();
    int pos, slot, bitidx;
    logic exp_b, exp_lr, exp_sd, prev_sd;
    do_reset();
    prev_sd = 1'b0;
    for (int k = 0; k < WIN; k++) drive_cycle(k < 1536);
    for (int k = 0; k < WIN; k++) begin
      drive_cycle(1'($urandom_range(0, 1)));
      pos    = (cyc - 1) % WIN;
      slot   = pos / 64;
      exp_b  = (pos % 64) >= 32;
      exp_lr = (slot >= 15) && (slot <= 30);
      bitidx = (slot < 16) ? 15 - slot : 31 - slot;
      exp_sd = frame_word[bitidx];
      vectors++; if (bclk !== exp_b) begin miscompares++; $display("FAIL bclk@%0d: got %b want %b", pos, bclk, exp_b); end
      vectors++; if (lrclk !== exp_lr) begin miscompares++; $display("FAIL lrclk@%0d: got %b want %b", pos, lrclk, exp_lr); end
      vectors++; if (sdata !== exp_sd) begin miscompares++; $display("FAIL sdata@%0d: got %b want %b", pos, sdata, exp_sd); end
      if (pos % 64 == 31) prev_sd = sdata;
      if (pos % 64 == 32) begin
        vectors++; if (sdata !== prev_sd) begin miscompares++; $display("FAIL sdata_stable@%0d: got %b want %b", pos, sdata, prev_sd); end
      end
    end
    vectors++; if (obs_q.size() < 1 || obs_q[0] !== 16384) begin miscompares++; $display("FAIL frame_sample: got %0d want 16384", obs_q.size() > 0 ? obs_q[0] : 0); end
  endtask

  task automatic test_clr_midframe();
    do_reset();
    while (cyc < WIN + 20 * 64 + 10) drive_cycle(1'($urandom_range(0, 1)));
    clr = 1'b1;
    #1;
    vectors++; if (sample_o !== 16'h0000) begin miscompares++; $display("FAIL clr_sample: got %h want 0000", sample_o); end
    vectors++; if (sample_valid !== 1'b0) begin miscompares++; $display("FAIL clr_valid: got %b want 0", sample_valid); end
    vectors++; if (bclk !== 1'b0) begin miscompares++; $display("FAIL clr_bclk: got %b want 0", bclk); end
    vectors++; if (lrclk !== 1'b0) begin miscompares++; $display("FAIL clr_lrclk: got %b want 0", lrclk); end
    vectors++; if (sdata !== 1'b0) begin miscompares++; $display("FAIL clr_sdata: got %b want 0", sdata); end
    repeat (5) @(posedge clk);
    #2 clr = 1'b0;
    reset_model();
    for (int k = 0; k < WIN + LAT + 1; k++) begin
      drive_cycle(1'b1);
      if (cyc <= WIN) begin
        vectors++; if (sdata !== 1'b0) begin miscompares++; $display("FAIL clr_first_frame@%0d: got %b want 0", cyc, sdata); end
      end
    end
    vectors++; if (obs_cyc_q.size() < 1 || obs_cyc_q[0] !== WIN + LAT) begin miscompares++; $display("FAIL clr_first_valid: got %0d want %0d", obs_cyc_q.size() > 0 ? obs_cyc_q[0] : -1, WIN + LAT); end
  endtask

  task automatic test_mute();
    do_reset();
    mute = 1'b1;
    repeat (WIN) drive_cycle(1'b1);
    mute = 1'b0;
    repeat (WIN + LAT + 1) drive_cycle(1'b1);
    vectors++; if (obs_q.size() !== 2) begin miscompares++; $display("FAIL mute_count: got %0d want 2", obs_q.size()); end
    vectors++; if (obs_q.size() < 1 || obs_q[0] !== 0) begin miscompares++; $display("FAIL mute_zero: got %0d want 0", obs_q.size() > 0 ? obs_q[0] : -1); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      vectors++; if (obs_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL mute_sample[%0d]: got %0d want %0d", i, obs_q[i], exp_q[i]); end
    end
  endtask

  initial begin
    reset_model();
    test_reset();
    test_const_low();
    test_const_high();
    test_toggle();
    test_random();
    test_frame();
    test_clr_midframe();
    test_mute();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
